// File: rtl/mpadd_pkg.sv
// Shared helpers for the pipelined multi-chunk adder:
// chunk width and WIDTH/STAGES legality.
package mpadd_pkg;

    function automatic int mpadd_chunk(input int width, input int stages);
        return width / stages;
    endfunction

    function automatic bit mpadd_legal(input int width, input int stages);
        return (width > 0) && (stages > 0) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/fadd.sv
// Single-bit full-adder cell.
module fadd (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/mpadd_stage.sv
// One chunk of the pipelined adder: CHUNK-bit ripple add
// built from fadd cells, carry-in from the previous stage.
module mpadd_stage
    import mpadd_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    logic [CHUNK:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CHUNK; i++) begin : g_fa
        fadd u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co = c[CHUNK];

endmodule

// File: rtl/mpadd.sv
// Pipelined carry-skewed adder, one CHUNK per stage, global stall.
// Define MPADD_OVF_EN to add the signed-overflow output ovf.
module mpadd
    import mpadd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
`ifdef MPADD_OVF_EN
    output logic             ovf,
`endif
    output logic             co
);

    localparam int CHUNK = mpadd_chunk(WIDTH, STAGES);

    if (!mpadd_legal(WIDTH, STAGES)) begin : g_bad
        $error("mpadd: WIDTH must be a multiple of STAGES");
    end

    logic en;

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int AW = WIDTH - k * CHUNK;
        localparam int SW = (k + 1) * CHUNK;

        logic [AW-1:0]    ax;
        logic [AW-1:0]    bx;
        logic [SW-1:0]    sq_d;
        logic [SW-1:0]    sq_q;
        logic [CHUNK-1:0] cs;
        logic             cin;
        logic             vin;
        logic             cn;
        logic             v_q;
        logic             c_q;

        if (k == 0) begin : g_in
            assign ax   = a;
            assign bx   = b;
            assign cin  = ci;
            assign vin  = in_valid;
            assign sq_d = cs;
        end else begin : g_in
            assign ax   = g_st[k-1].g_rem.ra_q;
            assign bx   = g_st[k-1].g_rem.rb_q;
            assign cin  = g_st[k-1].c_q;
            assign vin  = g_st[k-1].v_q;
            assign sq_d = {cs, g_st[k-1].sq_q};
        end

        mpadd_stage #(.CHUNK(CHUNK)) u_stage (
            .a  (ax[CHUNK-1:0]),
            .b  (bx[CHUNK-1:0]),
            .ci (cin),
            .s  (cs),
            .co (cn)
        );

        always_ff @(posedge clk) begin
            if (rst) begin
                v_q  <= 1'b0;
                c_q  <= 1'b0;
                sq_q <= '0;
            end else if (en) begin
                v_q  <= vin;
                c_q  <= cn;
                sq_q <= sq_d;
            end
        end

        // Unprocessed upper operand chunks ride along to later stages.
        if (AW > CHUNK) begin : g_rem
            logic [AW-CHUNK-1:0] ra_q;
            logic [AW-CHUNK-1:0] rb_q;

            always_ff @(posedge clk) begin
                if (en) begin
                    ra_q <= ax[AW-1:CHUNK];
                    rb_q <= bx[AW-1:CHUNK];
                end
            end
        end

`ifdef MPADD_OVF_EN
        if (k == STAGES - 1) begin : g_ovf
            logic ovf_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    ovf_q <= 1'b0;
                end else if (en) begin
                    ovf_q <= (ax[CHUNK-1] == bx[CHUNK-1]) &&
                             (cs[CHUNK-1] != ax[CHUNK-1]);
                end
            end
        end
`endif
    end

    assign en        = !g_st[STAGES-1].v_q || out_ready;
    assign in_ready  = !rst && en;
    assign out_valid = !rst && g_st[STAGES-1].v_q;
    assign s         = rst ? '0 : g_st[STAGES-1].sq_q;
    assign co        = !rst && g_st[STAGES-1].c_q;

`ifdef MPADD_OVF_EN
    assign ovf = !rst && g_st[STAGES-1].g_ovf.ovf_q;
`endif

endmodule

// File: tb/tb_mpadd.sv
// Bench for mpadd: 4-stage and 1-stage instances against a
// queue-based arithmetic reference model.
module tb_mpadd;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         out_ready;
    logic         ci;
    logic [W-1:0] a;
    logic [W-1:0] b;

    logic         in_ready;
    logic         out_valid;
    logic         co;
    logic [W-1:0] s;
    logic         in_ready1;
    logic         out_valid1;
    logic         co1;
    logic [W-1:0] s1;
`ifdef MPADD_OVF_EN
    logic         ovf;
    logic         ovf1;
`endif

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    logic [17:0] q[$];
    logic [17:0] q1[$];
    int          outcyc[$];

    always #5 clk = ~clk;

    mpadd #(.WIDTH(W), .STAGES(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
`ifdef MPADD_OVF_EN
        .ovf       (ovf),
`endif
        .co        (co)
    );

    mpadd #(.WIDTH(W), .STAGES(1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready1),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .out_valid (out_valid1),
        .out_ready (out_ready),
        .s         (s1),
`ifdef MPADD_OVF_EN
        .ovf       (ovf1),
`endif
        .co        (co1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic, result {ovf, co, s}.
    function automatic logic [17:0] model(input logic [W-1:0] x,
                                          input logic [W-1:0] y,
                                          input logic c);
        int unsigned u;
        int          sv;
        logic        o;
        u  = 32'(x) + 32'(y) + 32'(c);
        sv = int'($signed(x)) + int'($signed(y)) + int'(c);
        o  = (sv > 32767) || (sv < -32768);
`ifndef MPADD_OVF_EN
        o = 1'b0;
`endif
        return {o, u[16:0]};
    endfunction

    function automatic logic [17:0] obs0();
        logic o;
        o = 1'b0;
`ifdef MPADD_OVF_EN
        o = ovf;
`endif
        return {o, co, s};
    endfunction

    function automatic logic [17:0] obs1();
        logic o;
        o = 1'b0;
`ifdef MPADD_OVF_EN
        o = ovf1;
`endif
        return {o, co1, s1};
    endfunction

    // Called at a negedge with inputs already driven.
    task automatic cycle();
        logic [17:0] e;
        #1;
        if (out_valid && out_ready) begin
            outcyc.push_back(cyc);
            if (q.size() == 0) begin
                chk("s4_extra", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                chk("s4_result", 32'(obs0()), 32'(e));
            end
        end
        if (out_valid1 && out_ready) begin
            if (q1.size() == 0) begin
                chk("s1_extra", 32'd1, 32'd0);
            end else begin
                e = q1.pop_front();
                chk("s1_result", 32'(obs1()), 32'(e));
            end
        end
        if (in_valid && in_ready)  q.push_back(model(a, b, ci));
        if (in_valid && in_ready1) q1.push_back(model(a, b, ci));
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic c);
        in_valid = 1'b1;
        a        = x;
        b        = y;
        ci       = c;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 24 && (q.size() + q1.size()) != 0; i++)
            cycle();
        chk("drain_left", 32'(q.size() + q1.size()), 32'd0);
    endtask

    initial begin
        int n;
        int ghost;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        ci        = 1'b0;
        @(negedge clk);
        cycle();
        cycle();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_sum", 32'({co, s}), 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_rel_ready", 32'(in_ready), 32'd1);

        // Latency and basic sum.
        send(16'h1234, 16'h4321, 1'b0);
        chk("s1_latency", 32'(out_valid1), 32'd1);
        n = 1;
        while (!out_valid && n < 10) begin
            cycle();
            n++;
        end
        chk("s4_latency", 32'(n), 32'd4);
        chk("sum_5555", 32'({co, s}), 32'h05555);
        drain();

        // Wrap-around and overflow corners.
        send(16'hFFFF, 16'h0001, 1'b0);
        send(16'hFFFF, 16'hFFFF, 1'b1);
        send(16'h7FFF, 16'h0001, 1'b0);
        send(16'h8000, 16'h8000, 1'b0);
        send(16'h0000, 16'h0000, 1'b1);
        drain();

        // Back-to-back throughput.
        outcyc.delete();
        for (int i = 0; i < 8; i++)
            send(W'($urandom), W'($urandom), 1'($urandom));
        drain();
        chk("b2b_count", 32'(outcyc.size()), 32'd8);
        if (outcyc.size() == 8)
            chk("b2b_span", 32'(outcyc[7] - outcyc[0]), 32'd7);

        // Stall with a full pipeline.
        for (int i = 0; i < 4; i++)
            send(W'($urandom), W'($urandom), 1'($urandom));
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = W'($urandom);
            b        = W'($urandom);
            #1;
            chk("stall_ready", 32'(in_ready), 32'd0);
            chk("stall_valid", 32'(out_valid), 32'd1);
            if (q.size() != 0)
                chk("stall_hold", 32'(obs0()), 32'(q[0]));
            cycle();
        end
        drain();

        // Reset with transactions in flight.
        for (int i = 0; i < 3; i++)
            send(W'($urandom), W'($urandom), 1'($urandom));
        rst      = 1'b1;
        in_valid = 1'b1;
        cycle();
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_valid1", 32'(out_valid1), 32'd0);
        q.delete();
        q1.delete();
        cycle();
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(in_ready), 32'd1);
        ghost = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid || out_valid1) ghost++;
            cycle();
        end
        chk("rst_ghost", 32'(ghost), 32'd0);

        // Random traffic with random back-pressure.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom % 10) < 7;
            out_ready = ($urandom % 10) < 7;
            a         = ($urandom % 8 == 0) ? 16'hFFFF : W'($urandom);
            b         = ($urandom % 8 == 0) ? 16'h8000 : W'($urandom);
            ci        = 1'($urandom);
            cycle();
        end
        drain();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mpadd.md
MPADD -- requirements
Module: mpadd

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand/sum width in bits.
REQ-002 SHALL have parameter STAGES, default 4, number of pipeline stages; WIDTH mod STAGES == 0; CHUNK = WIDTH/STAGES.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operands a, b, ci valid this cycle.
REQ-006 SHALL have port in_ready  output  1  block accepts operands this cycle.
REQ-007 SHALL have port a  input  WIDTH  operand A, unsigned.
REQ-008 SHALL have port b  input  WIDTH  operand B, unsigned.
REQ-009 SHALL have port ci  input  1  carry-in.
REQ-010 SHALL have port out_valid  output  1  s/co hold a valid result.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result this cycle.
REQ-012 SHALL have port s  output  WIDTH  sum bits.
REQ-013 SHALL have port co  output  1  carry-out of bit WIDTH-1.

Function
REQ-014 SHALL compute {co,s} = a + b + ci, modulo 2^(WIDTH+1), for every accepted transaction.
REQ-015 SHALL process chunk k (bits k*CHUNK..k*CHUNK+CHUNK-1) in stage k; the inter-stage carry is registered; unprocessed higher chunks and finished lower sum chunks are skewed through registers.
REQ-016 SHALL accept a transaction when in_valid && in_ready at a rising clk edge.
REQ-017 SHALL present the result with out_valid=1 exactly STAGES cycles after acceptance when out_ready is held 1.
REQ-018 SHALL drive in_ready = !out_valid || out_ready (global stall); when stalled, every stage register holds its value.
REQ-019 SHALL hold s, co, out_valid stable while out_valid && !out_ready.
REQ-020 SHALL sustain one transaction per cycle with out_ready=1; bubbles (in_valid=0) propagate as invalid stage slots.
REQ-021 SHALL preserve transaction order; no transaction is dropped or duplicated.
REQ-022 SHALL, on wrap-around (sum >= 2^WIDTH), set co=1 and s to the low WIDTH bits.
REQ-023 SHALL support STAGES=1 (latency 1, single registered WIDTH-bit add).

Reset
REQ-024 SHALL, while rst=1, clear all stage valid bits, drive out_valid=0, s=0, co=0, in_ready=0.
REQ-025 SHALL discard in-flight transactions when rst asserts mid-operation; none emerges after rst deasserts.
REQ-026 SHALL drive in_ready=1 the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, with macro MPADD_OVF_EN defined, add output ovf (1 bit) = signed two's-complement overflow of a+b+ci, aligned with s, reset 0.
REQ-028 SHALL, without MPADD_OVF_EN, have no ovf port and no extra logic.

Structure
REQ-029 SHALL place the CHUNK-width calculation function and the WIDTH/STAGES legality check in shared package mpadd_pkg.
REQ-030 SHALL instantiate one sub-module mpadd_stage per stage: CHUNK-bit add of a chunk plus registered carry-in, built from the existing fadd full-adder cell.

Verification (WIDTH=16, STAGES=4 unless noted)
REQ-031 SHALL verify a=0x1234, b=0x4321, ci=0 -> s=0x5555, co=0, out_valid exactly 4 cycles after acceptance.
REQ-032 SHALL verify a=0xFFFF, b=0x0001, ci=0 -> s=0x0000, co=1; and a=0xFFFF, b=0xFFFF, ci=1 -> s=0xFFFF, co=1.
REQ-033 SHALL verify 8 back-to-back transactions with out_ready=1 -> 8 results on 8 consecutive cycles, in order.
REQ-034 SHALL verify out_ready=0 for 3 cycles with a full pipeline -> in_ready=0, s/co held, no loss; all results appear in order afterwards.
REQ-035 SHALL verify rst asserted with 3 transactions in flight -> out_valid=0 next cycle, none emerges later; in_ready=1 one cycle after rst deasserts.
REQ-036 SHALL verify, with MPADD_OVF_EN, a=0x7FFF, b=0x0001, ci=0 -> s=0x8000, ovf=1, co=0; and STAGES=1 latency 1.
